muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 92 +++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS-style HI/LO multiply/divide unit (shift-add multiply, restoring divide)
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rdreq,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t             state;
    logic               is_div, neg_q, neg_r, sa, sb, ge, dz;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   m, rem, q, abs_a, abs_b;
    logic [WIDTH:0]     sum, shifted, diff;
    logic [2*WIDTH-1:0] prod;
    // m holds the multiplicand or divisor; q starts as multiplier or dividend and ends as product low / quotient
    always_comb begin
        sa      = op[0] & a[WIDTH-1];
        sb      = op[0] & b[WIDTH-1];
        abs_a   = sa ? -a : a;
        abs_b   = sb ? -b : b;
        sum     = {1'b0, rem} + (q[0] ? {1'b0, m} : '0);
        shifted = {rem, q[WIDTH-1]};
        ge      = shifted >= {1'b0, m};
        diff    = shifted - {1'b0, m};
        prod    = neg_q ? -{rem, q} : {rem, q};
        dz      = m == '0;
    end
    assign stall = busy & (start | rdreq | mthi | mtlo);
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= CALC;
                        busy   <= 1'b1;
                        count  <= '0;
                        is_div <= op[1];
                        neg_q  <= sa ^ sb;
                        neg_r  <= sa;
                        m      <= op[1] ? abs_b : abs_a;
                        q      <= op[1] ? abs_a : abs_b;
                        rem    <= '0;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                CALC: begin
                    rem   <= is_div ? (ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]) : sum[WIDTH:1];
                    q     <= is_div ? {q[WIDTH-2:0], ge} : {sum[0], q[WIDTH-1:1]};
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    // a zero divisor leaves all-ones quotient and the dividend magnitude, uncorrected
                    if (is_div) begin
                        lo <= (neg_q & ~dz) ? -q : q;
                        hi <= (neg_r & ~dz) ? -rem : rem;
                    end else begin
                        {hi, lo} <= prod;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
